// File: rtl/jtag_master_pkg.sv
// ---------------------------------------------------------------------------
// jtag_master_pkg
// Shared types and TAP sequencing constants for the JTAG master engine.
//   op_e     : command opcodes carried on cmd_op_i
//   state_e  : engine FSM states
//   HDR_*/POST/RESET_TMS : TMS patterns, LSB is the first TCK period
// ---------------------------------------------------------------------------
package jtag_master_pkg;

    typedef enum logic [1:0] {
        OP_RESET    = 2'd0,
        OP_SHIFT_IR = 2'd1,
        OP_SHIFT_DR = 2'd2,
        OP_IDLE     = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRST,
        ST_HDR,
        ST_SHIFT,
        ST_POST,
        ST_RSP
    } state_e;

    // RTI -> Select-DR -> Capture-DR -> Shift-DR
    localparam logic [2:0] HDR_DR       = 3'b001;
    localparam int         HDR_DR_LEN   = 3;
    // RTI -> Select-DR -> Select-IR -> Capture-IR -> Shift-IR
    localparam logic [3:0] HDR_IR       = 4'b0011;
    localparam int         HDR_IR_LEN   = 4;
    // Exit1 -> Update -> RTI
    localparam logic [1:0] POST         = 2'b01;
    localparam int         POST_LEN     = 2;
    // Five ones reach Test-Logic-Reset from anywhere, the zero parks in RTI
    localparam logic [5:0] RESET_TMS    = 6'b011111;
    localparam int         RESET_LEN    = 6;
    localparam int         TRST_PERIODS = 2;

    // Header TMS pattern zero-extended to 8 bits so one index width fits all ops
    function automatic logic [7:0] hdr_pattern(input op_e op);
        logic [7:0] pat;
        pat = 8'h00;
        case (op)
            OP_RESET:    pat = {2'b00, RESET_TMS};
            OP_SHIFT_IR: pat = {4'b0000, HDR_IR};
            OP_SHIFT_DR: pat = {5'b00000, HDR_DR};
            default:     pat = 8'h00;
        endcase
        return pat;
    endfunction

    function automatic logic is_shift(input op_e op);
        return (op == OP_SHIFT_IR) || (op == OP_SHIFT_DR);
    endfunction

endpackage

// File: rtl/jtag_master_engine_tck_gen.sv
// ---------------------------------------------------------------------------
// jtag_tck_gen
// TCK divider. While en is high it produces back-to-back TCK periods, each a
// low phase followed by a high phase of CLK_DIV clk_i cycles.
//   en       : run; when low, TCK is held low and the phase state clears
//   tck      : registered TCK
//   fall_stb : combinational, the coming clk_i edge starts a low phase
//   rise_stb : combinational, the coming clk_i edge raises TCK
// ---------------------------------------------------------------------------
module jtag_tck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic en,
    output logic tck,
    output logic fall_stb,
    output logic rise_stb
);

    localparam int                CNT_W    = $clog2(CLK_DIV) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             started;

    // The very first edge after enable opens a low phase without waiting.
    assign fall_stb = en && (!started || (tck && (cnt == CNT_LAST)));
    assign rise_stb = en && started && !tck && (cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            tck     <= 1'b0;
            started <= 1'b0;
        end else if (!en) begin
            cnt     <= '0;
            tck     <= 1'b0;
            started <= 1'b0;
        end else if (fall_stb) begin
            cnt     <= '0;
            tck     <= 1'b0;
            started <= 1'b1;
        end else if (rise_stb) begin
            cnt     <= '0;
            tck     <= 1'b1;
        end else begin
            cnt     <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/jtag_master_engine.sv
// ---------------------------------------------------------------------------
// jtag_master_engine
// Command-driven JTAG initiator. Each command walks the TAP from Run-Test/Idle
// through the needed states and back, returning one response.
//   cmd_*  : valid/ready command stream (op, len, TDI data LSB first)
//   rsp_*  : valid/ready response stream, captured TDO right-aligned
//   jtag_* : TCK/TMS/TDI/TRSTn to the target, TDO from the target
// ---------------------------------------------------------------------------
module jtag_master_engine
    import jtag_master_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               clk_i,
    input  logic               rst_n,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [1:0]         cmd_op_i,
    input  logic [LEN_W-1:0]   cmd_len_i,
    input  logic [MAX_LEN-1:0] cmd_data_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [MAX_LEN-1:0] rsp_data_o,
    output logic               jtag_tck_o,
    output logic               jtag_tms_o,
    output logic               jtag_tdi_o,
    output logic               jtag_trst_no,
    input  logic               jtag_tdo_i
);

    localparam int IDX_W = $clog2(MAX_LEN);

    state_e             state;
    state_e             nxt_state;
    op_e                op_q;
    logic [LEN_W-1:0]   len_q;
    logic [MAX_LEN-1:0] data_q;
    logic [MAX_LEN-1:0] cap;
    logic [LEN_W-1:0]   idx;        // period index within the current state
    logic [LEN_W-1:0]   nxt_idx;
    logic [LEN_W-1:0]   phase_len;
    logic               active;     // a period has been presented for this command
    logic               nxt_tms;
    logic               nxt_tdi;
    logic               nxt_trst_n;
    logic [7:0]         hdr_pat;
    logic               tck_en;
    logic               fall_stb;
    logic               rise_stb;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (len == '0)                    return LEN_W'(1);
        else if (len > LEN_W'(MAX_LEN))   return LEN_W'(MAX_LEN);
        else                              return len;
    endfunction

    assign tck_en  = (state == ST_TRST) || (state == ST_HDR) ||
                     (state == ST_SHIFT) || (state == ST_POST);
    assign hdr_pat = hdr_pattern(op_q);

    jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
        .clk_i    (clk_i),
        .rst_n    (rst_n),
        .en       (tck_en),
        .tck      (jtag_tck_o),
        .fall_stb (fall_stb),
        .rise_stb (rise_stb)
    );

    // NOTE: every signal written in always_comb gets a default first so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        phase_len = LEN_W'(1);
        case (state)
            ST_TRST:  phase_len = LEN_W'(TRST_PERIODS);
            ST_HDR: begin
                case (op_q)
                    OP_RESET:    phase_len = LEN_W'(RESET_LEN);
                    OP_SHIFT_IR: phase_len = LEN_W'(HDR_IR_LEN);
                    OP_SHIFT_DR: phase_len = LEN_W'(HDR_DR_LEN);
                    default:     phase_len = len_q;   // OP_IDLE: len TMS=0 periods
                endcase
            end
            ST_SHIFT: phase_len = len_q;
            ST_POST:  phase_len = LEN_W'(POST_LEN);
            default:  phase_len = LEN_W'(1);
        endcase
    end

    // Which period comes next once the current one ends at a fall strobe.
    always_comb begin
        nxt_state = state;
        nxt_idx   = idx + LEN_W'(1);
        if (!active) begin
            nxt_idx = '0;
        end else if (idx == phase_len - LEN_W'(1)) begin
            nxt_idx = '0;
            case (state)
                ST_TRST:  nxt_state = ST_HDR;
                ST_HDR:   nxt_state = is_shift(op_q) ? ST_SHIFT : ST_RSP;
                ST_SHIFT: nxt_state = ST_POST;
                ST_POST:  nxt_state = ST_RSP;
                default:  nxt_state = state;
            endcase
        end
    end

    // Pin values for the next period; ST_RSP leaves TMS/TDI low, TRSTn high.
    always_comb begin
        nxt_tms    = 1'b0;
        nxt_tdi    = 1'b0;
        nxt_trst_n = 1'b1;
        case (nxt_state)
            ST_TRST: begin
                nxt_tms    = 1'b1;
                nxt_trst_n = 1'b0;
            end
            ST_HDR:   nxt_tms = hdr_pat[nxt_idx[2:0]];
            ST_SHIFT: begin
                nxt_tms = (nxt_idx == len_q - LEN_W'(1));   // last bit exits Shift
                nxt_tdi = data_q[nxt_idx[IDX_W-1:0]];
            end
            ST_POST:  nxt_tms = POST[nxt_idx[0]];
            default:  ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            op_q         <= OP_RESET;
            len_q        <= '0;
            data_q       <= '0;
            cap          <= '0;
            idx          <= '0;
            active       <= 1'b0;
            cmd_ready_o  <= 1'b0;
            rsp_valid_o  <= 1'b0;
            rsp_data_o   <= '0;
            jtag_tms_o   <= 1'b1;
            jtag_tdi_o   <= 1'b0;
            jtag_trst_no <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    jtag_trst_no <= 1'b1;
                    if (cmd_valid_i && cmd_ready_o) begin
                        cmd_ready_o <= 1'b0;
                        op_q        <= op_e'(cmd_op_i);
                        len_q       <= clamp_len(cmd_len_i);
                        data_q      <= cmd_data_i;
                        cap         <= '0;
                        idx         <= '0;
                        active      <= 1'b0;
                        state       <= (op_e'(cmd_op_i) == OP_RESET) ? ST_TRST : ST_HDR;
                    end else begin
                        cmd_ready_o <= 1'b1;
                    end
                end
                ST_TRST, ST_HDR, ST_SHIFT, ST_POST: begin
                    if (rise_stb && (state == ST_SHIFT)) begin
                        cap[idx[IDX_W-1:0]] <= jtag_tdo_i;
                    end
                    if (fall_stb) begin
                        active       <= 1'b1;
                        state        <= nxt_state;
                        idx          <= nxt_idx;
                        jtag_tms_o   <= nxt_tms;
                        jtag_tdi_o   <= nxt_tdi;
                        jtag_trst_no <= nxt_trst_n;
                        if (nxt_state == ST_RSP) begin
                            rsp_valid_o <= 1'b1;
                            rsp_data_o  <= cap;
                        end
                    end
                end
                ST_RSP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        cmd_ready_o <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
